window_gen_3x3: RTL and testbench
=================================

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 Parameter IMG_WIDTH, default 1600, pixels per line; legal range 3..1600.
REQ-002 Parameter IMG_HEIGHT, default 1200, lines per frame; legal range 3..4095.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pix_in  input  8  raster-order pixel, sampled when pix_valid=1.
REQ-006 pix_valid  input  1  pixel strobe; gaps of any length allowed.
REQ-007 lb0_addr  output  11  address to line buffer 0.
REQ-008 lb0_we  output  1  write enable to line buffer 0.
REQ-009 lb0_din  output  8  write data to line buffer 0.
REQ-010 lb0_dout  input  8  line buffer 0 read data.
REQ-011 lb1_addr / lb1_we / lb1_din  output  11/1/8  same roles for line buffer 1.
REQ-012 lb1_dout  input  8  line buffer 1 read data.
REQ-013 win  output  72  3x3 window; byte win[8*(3*i+j)+:8] = row i (0 oldest), column j (0 oldest); centre i=1, j=1.
REQ-014 win_valid  output  1  win holds a complete in-frame window for one cycle.

Function
REQ-015 Line buffers are external single-port RAMs: 1-cycle registered read, read-before-write on the same address.
REQ-016 col (11 b) and row (12 b) counters advance only on pix_valid; col wraps IMG_WIDTH-1 -> 0 and increments row; row wraps IMG_HEIGHT-1 -> 0.
REQ-017 Cycle t (pix_valid=1): lb0_addr=col, lb0_we=1, lb0_din=pix_in; with pix_valid=0, lb0_we=0.
REQ-018 Cycle t+1: lb1_addr=col delayed 1, lb1_we=pix_valid delayed 1, lb1_din=lb0_dout (row-1 pixel is cascaded into buffer 1).
REQ-019 Cycle t+2: column {lb1_dout, lb0_dout delayed 1, pix_in delayed 2} = rows {row-2, row-1, row} is valid; col/row tags travel with it.
REQ-020 The window register shifts one column left only when a valid column arrives; otherwise it holds.
REQ-021 win/win_valid are registered: the column from pixel at cycle t appears at cycle t+3; latency fixed at 3 cycles regardless of gaps.
REQ-022 win_valid=1 iff the pixel tag has col>=2 and row>=2; the window centre is then (row-1, col-1).
REQ-023 Windows straddling a line wrap (col 0,1) and rows 0,1 of every frame produce win_valid=0; win contents are don't-care then.
REQ-024 Throughput: one window per cycle under back-to-back pix_valid.

Reset
REQ-025 rst_n=0 asynchronously clears col, row, all delay/valid stages, window register, win=0, win_valid=0, lb0_we=0, lb1_we=0, addresses=0, data outputs=0.
REQ-026 Reset mid-frame restarts at (row 0, col 0); stale line buffer contents are never exposed because REQ-022 gating suppresses rows 0-1.
REQ-027 First pixel accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro WINDOW_GEN_FRAME_FLAGS_EN: when defined, outputs win_sof (1 b) and win_eol (1 b) exist; win_sof=1 with the first valid window of a frame (centre (1,1)), win_eol=1 with the last valid window of a line (centre col IMG_WIDTH-2); both aligned with win_valid and reset to 0.
REQ-029 Without the macro the ports and their logic are absent; all other behaviour is identical.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, behavioural line buffers; pixel value = 8*row+col)
REQ-030 Continuous frame -> first win_valid 3 cycles after pixel (2,2); win = {0,1,2,8,9,10,16,17,18}; 24 valid windows per frame.
REQ-031 pix_valid toggled 1/0 every cycle -> same 24 windows, same contents, each 3 cycles after its triggering pixel.
REQ-032 Pixels (r,0),(r,1) for r>=2 -> win_valid=0; pixel (3,2) -> win = {8,9,10,16,17,18,24,25,26}.
REQ-033 rst_n low for 1 cycle after pixel (4,5) -> win_valid=0 until pixel (2,2) of the restarted frame; no stale window emitted.
REQ-034 Two frames back-to-back -> frame 2 rows 0-1 give win_valid=0; first frame-2 window identical to REQ-030.
REQ-035 With WINDOW_GEN_FRAME_FLAGS_EN -> win_sof on pixel (2,2) window only; win_eol on pixels (r,7), r=2..5.

Source files
------------

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 pixel window generator fed by two external line buffers.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pix_in, pix_valid     raster-order 8-bit pixel stream, gaps allowed
//   lb0_addr/we/din/dout  line buffer 0 (holds row-1), 1-cycle read, read-before-write
//   lb1_addr/we/din/dout  line buffer 1 (holds row-2), fed by cascading lb0 read data
//   win                   3x3 window, byte 3*i+j = row i (0 oldest), column j (0 oldest)
//   win_valid             win is a complete in-frame window this cycle
//   win_sof, win_eol      first window of frame / last window of line
//                         (present only when WINDOW_GEN_FRAME_FLAGS_EN is defined)
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 1600,
  parameter int IMG_HEIGHT = 1200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic [10:0] lb0_addr,
  output logic        lb0_we,
  output logic [7:0]  lb0_din,
  input  logic [7:0]  lb0_dout,
  output logic [10:0] lb1_addr,
  output logic        lb1_we,
  output logic [7:0]  lb1_din,
  input  logic [7:0]  lb1_dout,
  output logic [71:0] win,
`ifdef WINDOW_GEN_FRAME_FLAGS_EN
  output logic        win_sof,
  output logic        win_eol,
`endif
  output logic        win_valid
);
  localparam logic [10:0] LAST_COL = 11'(IMG_WIDTH - 1);
  localparam logic [11:0] LAST_ROW = 12'(IMG_HEIGHT - 1);
  logic [10:0] r_col, r_col_d1, r_col_d2;
  logic [11:0] r_row, r_row_d1, r_row_d2;
  logic        r_v1, r_v2;
  logic [7:0]  r_pix_d1, r_pix_d2, r_lb0_d;
  logic [71:0] r_win;
  logic        r_win_valid;
  logic        w_act, w_in_frame;
  // Gate the write port with reset so nothing is written while reset is held.
  assign w_act      = pix_valid & rst_n;
  assign lb0_addr   = r_col;
  assign lb0_we     = w_act;
  assign lb0_din    = w_act ? pix_in : 8'd0;
  assign lb1_addr   = r_col_d1;
  assign lb1_we     = r_v1;
  assign lb1_din    = r_v1 ? lb0_dout : 8'd0;
  // Rows 0-1 and the first two columns of each line hold stale/wrapped data.
  assign w_in_frame = r_v2 && (r_col_d2 >= 11'd2) && (r_row_d2 >= 12'd2);
  assign win        = r_win;
  assign win_valid  = r_win_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_col_d1    <= '0;
      r_row_d1    <= '0;
      r_col_d2    <= '0;
      r_row_d2    <= '0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_pix_d1    <= '0;
      r_pix_d2    <= '0;
      r_lb0_d     <= '0;
      r_win       <= '0;
      r_win_valid <= 1'b0;
    end else begin
      if (pix_valid) begin
        r_col <= (r_col == LAST_COL) ? 11'd0 : r_col + 11'd1;
        if (r_col == LAST_COL) r_row <= (r_row == LAST_ROW) ? 12'd0 : r_row + 12'd1;
      end
      r_v1        <= pix_valid;
      r_col_d1    <= r_col;
      r_row_d1    <= r_row;
      r_pix_d1    <= pix_in;
      r_v2        <= r_v1;
      r_col_d2    <= r_col_d1;
      r_row_d2    <= r_row_d1;
      r_pix_d2    <= r_pix_d1;
      r_lb0_d     <= lb0_dout;
      r_win_valid <= w_in_frame;
      // Each row drops its oldest byte and takes the new column byte at j=2.
      if (r_v2) r_win <= {r_pix_d2, r_win[71:56], r_lb0_d, r_win[47:32], lb1_dout, r_win[23:8]};
    end
  end
`ifdef WINDOW_GEN_FRAME_FLAGS_EN
  logic r_sof, r_eol;
  assign win_sof = r_sof;
  assign win_eol = r_eol;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sof <= 1'b0;
      r_eol <= 1'b0;
    end else begin
      r_sof <= w_in_frame && (r_row_d2 == 12'd2) && (r_col_d2 == 11'd2);
      r_eol <= w_in_frame && (r_col_d2 == LAST_COL);
    end
  end
`endif
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: scoreboard bench for window_gen_3x3 on an 8x6 image with behavioural line buffers.
module tb_window_gen_3x3;
  localparam int W = 8;
  localparam int H = 6;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic [10:0] lb0_addr, lb1_addr;
  logic        lb0_we, lb1_we;
  logic [7:0]  lb0_din, lb1_din, lb0_dout, lb1_dout;
  logic [71:0] win;
  logic        win_valid;
`ifdef WINDOW_GEN_FRAME_FLAGS_EN
  logic        win_sof, win_eol;
`endif
  window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .lb0_addr(lb0_addr), .lb0_we(lb0_we), .lb0_din(lb0_din), .lb0_dout(lb0_dout),
    .lb1_addr(lb1_addr), .lb1_we(lb1_we), .lb1_din(lb1_din), .lb1_dout(lb1_dout),
    .win(win),
`ifdef WINDOW_GEN_FRAME_FLAGS_EN
    .win_sof(win_sof), .win_eol(win_eol),
`endif
    .win_valid(win_valid)
  );
  always #5 clk = ~clk;
  logic [7:0] mem0 [0:2047];
  logic [7:0] mem1 [0:2047];
  always @(posedge clk) begin
    lb0_dout <= mem0[lb0_addr];
    lb1_dout <= mem1[lb1_addr];
    if (lb0_we) mem0[lb0_addr] <= lb0_din;
    if (lb1_we) mem1[lb1_addr] <= lb1_din;
  end
  typedef struct {
    logic [71:0] w;
    int          c;
    logic        sof;
    logic        eol;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_win = 0;
  int   tr = 0;
  int   tc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [71:0] model(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j)+:8] = 8'(8*(r-2+i) + (c-2+j));
    return w;
  endfunction
  task automatic send();
    exp_t e;
    pix_in    = 8'(8*tr + tc);
    pix_valid = 1'b1;
    if (tr >= 2 && tc >= 2) begin
      e.w   = model(tr, tc);
      e.c   = cyc + 3;
      e.sof = (tr == 2 && tc == 2);
      e.eol = (tc == W-1);
      q.push_back(e);
    end
    tc = (tc == W-1) ? 0 : tc + 1;
    if (tc == 0) tr = (tr == H-1) ? 0 : tr + 1;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_in    = 8'($urandom);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (win_valid) begin
        n_win++;
        if (q.size() == 0) chk("unexpected_valid", 72'(win_valid), 72'(0));
        else begin
          m_e = q.pop_front();
          chk("win", win, m_e.w);
          chk("latency", 72'(cyc), 72'(m_e.c));
`ifdef WINDOW_GEN_FRAME_FLAGS_EN
          chk("sof", 72'(win_sof), 72'(m_e.sof));
          chk("eol", 72'(win_eol), 72'(m_e.eol));
`endif
        end
      end else if (q.size() > 0 && q[0].c <= cyc) begin
        chk("missing_window", 72'(win_valid), 72'(1));
        void'(q.pop_front());
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem0[i] = 8'($urandom);
      mem1[i] = 8'($urandom);
    end
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_in    = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_win", win, 72'(0));
    chk("rst_win_valid", 72'(win_valid), 72'(0));
    chk("rst_lb0_we", 72'(lb0_we), 72'(0));
    chk("rst_lb1_we", 72'(lb1_we), 72'(0));
    chk("rst_lb0_addr", 72'(lb0_addr), 72'(0));
    chk("rst_lb1_addr", 72'(lb1_addr), 72'(0));
    chk("rst_lb1_din", 72'(lb1_din), 72'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < W*H; k++) send();
    for (int k = 0; k < W*H; k++) begin
      send();
      idle(1);
    end
    idle(5);
    chk("two_frame_window_count", 72'(n_win), 72'(48));
    for (int k = 0; k < 4*W + 6; k++) send();
    rst_n = 1'b0;
    q.delete();
    tr = 0;
    tc = 0;
    @(negedge clk);
    chk("midrst_win_valid", 72'(win_valid), 72'(0));
    chk("midrst_win", win, 72'(0));
    chk("midrst_lb1_we", 72'(lb1_we), 72'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_win = 0;
    for (int k = 0; k < W*H; k++) begin
      send();
      idle($urandom_range(0, 3));
    end
    idle(6);
    chk("gap_frame_window_count", 72'(n_win), 72'(24));
    chk("queue_empty", 72'(q.size()), 72'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
